cc_mailbox: RTL and testbench
=============================

Name: cc_mailbox

Overview:
- Port-mapped responder on the KCPSM6 command-control I/O bus, driven by the processor's port_id, port_out, write_strobe, k_write_strobe and read_strobe outputs.
- Returns read data on port_in and raises interrupt until interrupt_ack.
- Buffers bytes in both directions between the soft processor and the analyzer fabric:
  - RX FIFO: fabric to CPU (capture events, status bytes).
  - TX FIFO: CPU to fabric (command bytes).
- Sits beside command_control. Its port_in contribution is OR-combined with other peripherals.

Parameters:
BASE_ID, 8'h10, port_id of register 0; occupies BASE_ID..BASE_ID+3, BASE_ID[1:0] must be 0
K_ID, 4'h1, port_id[3:0] decoded for OUTPUTK to CONTROL (used only with the optional feature)
RX_DEPTH, 16, RX FIFO entries, power of two, 2..256
TX_DEPTH, 16, TX FIFO entries, power of two, 2..256

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
port_id  in  8  processor port address
port_out  in  8  processor write data
write_strobe  in  1  OUTPUT qualifier
k_write_strobe  in  1  OUTPUTK qualifier
read_strobe  in  1  INPUT qualifier (second cycle of INPUT)
port_in  out  8  registered read data, 8'h00 when not addressed
interrupt  out  1  level interrupt request to processor
interrupt_ack  in  1  processor acknowledge
rx_data  in  8  fabric byte toward CPU
rx_valid  in  1  rx_data present
rx_ready  out  1  RX FIFO not full
tx_data  out  8  FIFO head toward fabric
tx_valid  out  1  TX FIFO not empty
tx_ready  in  1  fabric consumes head when tx_valid&tx_ready

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - FIFOs empty; port_in=0; interrupt=0; irq_en=0; overflow=0.
  - rx_ready=1; tx_valid=0; tx_data=0.
- Register map:
  - +0 STATUS (R): {4'b0, overflow, tx_full, rx_full, rx_not_empty}.
  - +1 RX_DATA (R): RX FIFO head, 8'h00 if empty.
  - +2 TX_DATA (W): push.
  - +3 CONTROL (W): bit0 irq_en, bit1 clear overflow (write-1, not stored).
  - Reads of +2/+3 return 8'h00. Writes to +0/+1 are ignored.
- Read path: port_in is registered every cycle from a mux on port_id. Value at cycle n+1 reflects state and port_id at cycle n. This meets KCPSM6 two-cycle INPUT timing.
- RX pop: on read_strobe & port_id==BASE_ID+1 & !empty, pop at that clock edge. The head value was already captured in port_in the previous cycle. Reading an empty FIFO does not pop.
- TX push: on write_strobe & port_id==BASE_ID+2. If full, the byte is dropped and the FIFO is unchanged.
- RX push: on rx_valid & rx_ready. If rx_valid & full, overflow is set (sticky). It is cleared only by the CONTROL bit1 write or by reset.
- Simultaneous push and pop on the same FIFO in the same cycle:
  - Both happen; count is unchanged.
  - When full, the pop frees the slot first, so the push succeeds.
  - When empty, only the push happens.
- Interrupt, one pending flag:
  - Set when irq_en=1 and RX goes from empty to not-empty.
  - Also set when irq_en is written 1 while RX is non-empty.
  - Cleared on interrupt_ack.
  - If set and ack occur in the same cycle, set wins.
  - irq_en written 0 clears pending.
  - interrupt = pending.
- Pointers: log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits; wrap modulo DEPTH.
- tx_data/tx_valid show the FIFO head combinationally from registered storage. Pop on tx_valid & tx_ready.
- Reset mid-transfer discards all FIFO contents. There is no partial-byte state.

Optional Feature:
- CC_MAILBOX_KWRITE_EN defined:
  - k_write_strobe with port_id[3:0]==K_ID writes CONTROL from port_out, with the same semantics as OUTPUT to +3.
  - If write_strobe and k_write_strobe decode in the same cycle, write_strobe wins.
- Undefined: k_write_strobe is ignored entirely.

Decomposition:
- Package cc_mailbox_pkg holds:
  - Register offsets: REG_STATUS=0, REG_RX=1, REG_TX=2, REG_CTRL=3.
  - STATUS bit indices and CONTROL bit indices.
  - Function clog2.
- One sub-module, cc_sync_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count). It is instantiated twice: RX and TX.

Test Plan:
- Reset, then INPUT from BASE_ID+0 -> port_in=8'h00. Then push rx_data=8'hA5 -> STATUS read 8'h01, RX_DATA read 8'hA5, STATUS read 8'h00.
- Write CONTROL 8'h01, push 8'h3C -> interrupt=1 one cycle later. Hold ack off: stays 1. interrupt_ack pulse -> 0. Second push while non-empty -> no new interrupt.
- Push 17 bytes 0..16 into RX with RX_DEPTH=16 -> rx_ready=0 after 16. STATUS=8'h0B (overflow|full|not_empty). Write CONTROL 8'h02 -> overflow=0. Reads return 0..15 in order.
- OUTPUT 8'h11,8'h22 to BASE_ID+2 with tx_ready=0 -> tx_valid=1, tx_data=8'h11. tx_ready=1 for 2 cycles -> bytes 8'h11 then 8'h22, then tx_valid=0.
- RX full plus simultaneous read pop and rx_valid push -> count stays 16, no overflow, new byte appears last.
- With CC_MAILBOX_KWRITE_EN: OUTPUTK 8'h01 to K_ID -> irq_en=1. Without the macro: same stimulus leaves irq_en=0.

Source files
------------

// File: rtl/cc_mailbox_pkg.sv
// Shared constants for the command-control mailbox:
// register offsets, STATUS/CONTROL bit indices, clog2 helper.
package cc_mailbox_pkg;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_RX     = 2'd1,
    REG_TX     = 2'd2,
    REG_CTRL   = 2'd3
  } reg_e;

  localparam int ST_RX_NE   = 0;
  localparam int ST_RX_FULL = 1;
  localparam int ST_TX_FULL = 2;
  localparam int ST_OVF     = 3;

  localparam int CT_IRQ_EN  = 0;
  localparam int CT_OVF_CLR = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cc_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, head shown combinationally.
// Ports: clk, reset, push, pop, din -> dout, full, empty, count.
module cc_sync_fifo
  import cc_mailbox_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign count = cnt_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the
  // same-cycle push lands in.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push) begin
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
      mem_d[wr_ptr_q] = din;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cc_mailbox.sv
// KCPSM6 port-mapped mailbox: RX/TX byte FIFOs, STATUS/CONTROL
// registers, level interrupt. Ports: KCPSM6 I/O bus (port_id,
// port_out, write_strobe, k_write_strobe, read_strobe, port_in,
// interrupt, interrupt_ack), fabric rx_* in and tx_* out.
// Optional CC_MAILBOX_KWRITE_EN: OUTPUTK to K_ID writes CONTROL.
module cc_mailbox
  import cc_mailbox_pkg::*;
#(
  parameter logic [7:0] BASE_ID  = 8'h10,
  parameter logic [3:0] K_ID     = 4'h1,
  parameter int         RX_DEPTH = 16,
  parameter int         TX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] port_out,
  input  logic       write_strobe,
  input  logic       k_write_strobe,
  input  logic       read_strobe,
  output logic [7:0] port_in,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  logic [7:0] port_in_q, port_in_d;
  logic       irq_en_q, irq_en_d;
  logic       ovf_q, ovf_d;
  logic       pend_q, pend_d;

  logic       hit;
  logic [1:0] off;
  logic       sel_st, sel_rx;
  logic       wr_tx, wr_ctl, k_ctl, ctl_wr;
  logic       irq_set;
  logic [7:0] status;

  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_dout;
  logic       tx_full, tx_empty;
  logic [7:0] tx_dout;

  logic [clog2(RX_DEPTH):0] rx_count;
  logic [clog2(TX_DEPTH):0] tx_count;
  logic                     unused_cnt;

  assign unused_cnt = ^{rx_count, tx_count};

  assign hit    = (port_id[7:2] == BASE_ID[7:2]);
  assign off    = port_id[1:0];
  assign sel_st = hit & (off == REG_STATUS);
  assign sel_rx = hit & (off == REG_RX);
  assign wr_tx  = write_strobe & hit & (off == REG_TX);
  assign wr_ctl = write_strobe & hit & (off == REG_CTRL);

`ifdef CC_MAILBOX_KWRITE_EN
  // OUTPUT and OUTPUTK share port_out; write_strobe simply
  // takes precedence when both are present.
  assign k_ctl = k_write_strobe & ~write_strobe
               & (port_id[3:0] == K_ID);
`else
  logic k_unused;
  assign k_unused = k_write_strobe;
  assign k_ctl    = 1'b0;
`endif

  assign ctl_wr = wr_ctl | k_ctl;

  assign rx_pop  = read_strobe & sel_rx & ~rx_empty;
  assign rx_push = rx_valid & (~rx_full | rx_pop);

  cc_sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  cc_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .pop   (tx_ready),
    .din   (port_out),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign rx_ready  = ~rx_full;
  assign tx_valid  = ~tx_empty;
  assign tx_data   = tx_dout;
  assign port_in   = port_in_q;
  assign interrupt = pend_q;

  always_comb begin
    status             = '0;
    status[ST_RX_NE]   = ~rx_empty;
    status[ST_RX_FULL] = rx_full;
    status[ST_TX_FULL] = tx_full;
    status[ST_OVF]     = ovf_q;
  end

  always_comb begin
    port_in_d = '0;
    unique case (1'b1)
      sel_st:  port_in_d = status;
      sel_rx:  port_in_d = rx_dout;
      default: port_in_d = '0;
    endcase
  end

  // Pending fires on the RX empty->non-empty edge, or when
  // interrupts are enabled with data already (or just) queued.
  assign irq_set =
      (irq_en_q & rx_empty & rx_push)
    | (ctl_wr & port_out[CT_IRQ_EN] & (~rx_empty | rx_push));

  always_comb begin
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    pend_d   = pend_q;
    if (ctl_wr) irq_en_d = port_out[CT_IRQ_EN];
    if (ctl_wr & port_out[CT_OVF_CLR]) ovf_d = 1'b0;
    // A drop in the clearing cycle is kept, not lost.
    if (rx_valid & rx_full & ~rx_pop) ovf_d = 1'b1;
    if (interrupt_ack) pend_d = 1'b0;
    if (irq_set) pend_d = 1'b1;
    if (ctl_wr & ~port_out[CT_IRQ_EN]) pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_in_q <= '0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      port_in_q <= port_in_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      pend_q    <= pend_d;
    end
  end

endmodule

// File: tb/tb_cc_mailbox.sv
// Scoreboard bench for cc_mailbox: queue-based reference model,
// directed scenarios followed by randomized bus/fabric traffic.
module tb_cc_mailbox;

  localparam logic [7:0] BASE = 8'h10;
  localparam logic [3:0] KID  = 4'h1;
  localparam int         DEP  = 16;
  localparam logic [7:0] A_ST = BASE;
  localparam logic [7:0] A_RX = BASE + 8'd1;
  localparam logic [7:0] A_TX = BASE + 8'd2;
  localparam logic [7:0] A_CT = BASE + 8'd3;
`ifdef CC_MAILBOX_KWRITE_EN
  localparam bit KW = 1'b1;
`else
  localparam bit KW = 1'b0;
`endif

  logic       clk, reset;
  logic [7:0] port_id, port_out, port_in;
  logic       write_strobe, k_write_strobe, read_strobe;
  logic       interrupt, interrupt_ack;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;

  cc_mailbox #(
    .BASE_ID  (BASE),
    .K_ID     (KID),
    .RX_DEPTH (DEP),
    .TX_DEPTH (DEP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .port_id        (port_id),
    .port_out       (port_out),
    .write_strobe   (write_strobe),
    .k_write_strobe (k_write_strobe),
    .read_strobe    (read_strobe),
    .port_in        (port_in),
    .interrupt      (interrupt),
    .interrupt_ack  (interrupt_ack),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] mrx[$];
  logic [7:0] mtx[$];
  bit m_ovf, m_en, m_pend;
  // Scoreboards
  logic [7:0] sb_rd[$];
  logic [7:0] sb_tx[$];
  // Expected levels for the current cycle
  bit e_irq, e_rdy, e_tv;
  logic [7:0] e_txd;
  int errs = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %02h expected %02h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [7:0] pid);
    logic [7:0] s;
    if (pid[7:2] != BASE[7:2]) return 8'h00;
    case (pid[1:0])
      2'd0: begin
        s = 8'h00;
        s[0] = (mrx.size() != 0);
        s[1] = (mrx.size() == DEP);
        s[2] = (mtx.size() == DEP);
        s[3] = m_ovf;
        return s;
      end
      2'd1: return (mrx.size() != 0) ? mrx[0] : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // One bus cycle; model advances as the closing edge will.
  task automatic cyc(input bit ws, ks, rs,
                     input logic [7:0] pid, pout,
                     input bit rxv, input logic [7:0] rxd,
                     input bit txr, ack, rst, prd);
    @(posedge clk);
    #1;
    e_irq = m_pend;
    e_rdy = (mrx.size() < DEP);
    e_tv  = (mtx.size() > 0);
    e_txd = e_tv ? mtx[0] : 8'h00;
    write_strobe   = ws;
    k_write_strobe = ks;
    read_strobe    = rs;
    port_id        = pid;
    port_out       = pout;
    rx_valid       = rxv;
    rx_data        = rxd;
    tx_ready       = txr;
    interrupt_ack  = ack;
    reset          = rst;
    if (prd) sb_rd.push_back(exp_read(pid));
    if (rst) begin
      mrx.delete();
      mtx.delete();
      m_ovf  = 1'b0;
      m_en   = 1'b0;
      m_pend = 1'b0;
    end else begin
      bit re, rf, rpop, rpush, ovs, tpop, tpush, ctl, set;
      re    = (mrx.size() == 0);
      rf    = (mrx.size() == DEP);
      rpop  = rs && pid == A_RX && !re;
      rpush = rxv && (!rf || rpop);
      ovs   = rxv && rf && !rpop;
      tpop  = txr && mtx.size() > 0;
      tpush = ws && pid == A_TX && (mtx.size() < DEP || tpop);
      ctl   = (ws && pid == A_CT)
           || (KW && ks && !ws && pid[3:0] == KID);
      set   = (m_en && re && rpush)
           || (ctl && pout[0] && (!re || rpush));
      if (rpop) void'(mrx.pop_front());
      if (rpush) mrx.push_back(rxd);
      if (tpop) sb_tx.push_back(mtx.pop_front());
      if (tpush) mtx.push_back(pout);
      if (ctl && pout[1]) m_ovf = 1'b0;
      if (ovs) m_ovf = 1'b1;
      if (ack) m_pend = 1'b0;
      if (set) m_pend = 1'b1;
      if (ctl && !pout[0]) m_pend = 1'b0;
      if (ctl) m_en = pout[0];
    end
  endtask

  task automatic idle(input int n, input bit txr);
    repeat (n) cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, txr, 0, 0, 0);
  endtask

  task automatic wr(input logic [7:0] a, d);
    cyc(1, 0, 0, a, d, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [7:0] a);
    cyc(0, 0, 0, a, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    cyc(0, 0, 1, a, 8'h00, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic rxp(input logic [7:0] d);
    cyc(0, 0, 0, 8'h00, 8'h00, 1, d, 0, 0, 0, 0);
  endtask

  // Monitor: compares whenever the DUT presents a result.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("interrupt", {7'b0, interrupt}, {7'b0, e_irq});
      chk("rx_ready", {7'b0, rx_ready}, {7'b0, e_rdy});
      chk("tx_valid", {7'b0, tx_valid}, {7'b0, e_tv});
      chk("tx_data", tx_data, e_txd);
      if (read_strobe) begin
        if (sb_rd.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL rd_extra: read with no expectation at %0t",
                   $time);
        end else begin
          chk("port_in", port_in, sb_rd.pop_front());
        end
      end
      if (tx_valid && tx_ready) begin
        if (sb_tx.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL tx_extra: byte %02h not expected at %0t",
                   tx_data, $time);
        end else begin
          chk("tx_byte", tx_data, sb_tx.pop_front());
        end
      end
    end
  end

  function automatic bit rnd(input int n);
    return $urandom_range(0, n - 1) == 0;
  endfunction

  initial begin
    reset = 1'b1;
    write_strobe = 0; k_write_strobe = 0; read_strobe = 0;
    port_id = 0; port_out = 0; rx_valid = 0; rx_data = 0;
    tx_ready = 0; interrupt_ack = 0;
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_port_in", port_in, 8'h00);
    chk("rst_irq", {7'b0, interrupt}, 8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk_on = 1'b1;

    // Basic RX path
    rd(A_ST);
    rxp(8'hA5);
    rd(A_ST);
    rd(A_RX);
    rd(A_ST);

    // Interrupt set / hold / ack / no retrigger
    wr(A_CT, 8'h01);
    rxp(8'h3C);
    idle(3, 0);
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 0, 0);
    idle(1, 0);
    rxp(8'h77);
    idle(2, 0);
    rd(A_RX);
    rd(A_RX);

    // RX overflow and ordering
    for (int i = 0; i < 17; i++) rxp(8'(i));
    rd(A_ST);
    wr(A_CT, 8'h02);
    rd(A_ST);
    for (int i = 0; i < 16; i++) rd(A_RX);
    rd(A_ST);

    // TX path with back-pressure
    wr(A_TX, 8'h11);
    wr(A_TX, 8'h22);
    idle(2, 0);
    idle(2, 1);
    idle(1, 0);

    // Full RX with pop and push in one cycle
    for (int i = 0; i < 16; i++) rxp(8'(8'h40 + i));
    cyc(0, 0, 0, A_RX, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    cyc(0, 0, 1, A_RX, 8'h00, 1, 8'hEE, 0, 0, 0, 0);
    rd(A_ST);
    for (int i = 0; i < 16; i++) rd(A_RX);
    rd(A_ST);

    // OUTPUTK to CONTROL (effective only with the option)
    cyc(0, 1, 0, {4'h0, KID}, 8'h01, 0, 8'h00, 0, 0, 0, 0);
    rxp(8'h5A);
    idle(2, 0);
    wr(A_CT, 8'h00);
    rd(A_RX);

    // Reset discards buffered data
    rxp(8'h12);
    wr(A_TX, 8'h34);
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    rd(A_ST);
    rd(A_RX);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [7:0] a;
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 5))
        0, 1:    a = A_ST;
        2, 3, 4: a = A_RX;
        default: a = 8'($urandom);
      endcase
      case (r)
        0, 1, 2, 3: begin
          cyc(0, 0, 0, a, 8'h00, rnd(3), 8'($urandom),
              rnd(2), rnd(8), 0, 1);
          cyc(0, 0, 1, a, 8'h00, rnd(3), 8'($urandom),
              rnd(2), rnd(8), 0, 0);
        end
        4, 5:
          cyc(1, 0, 0, A_TX, 8'($urandom), rnd(3), 8'($urandom),
              rnd(2), rnd(8), 0, 0);
        6:
          cyc(1, 0, 0, A_CT, {6'b0, rnd(3), !rnd(4)}, rnd(3),
              8'($urandom), rnd(2), rnd(8), 0, 0);
        7:
          cyc(rnd(4), 1, 0, {4'h0, KID}, {6'b0, rnd(2), rnd(2)},
              rnd(3), 8'($urandom), rnd(2), rnd(8), 0, 0);
        8:
          cyc(1, 0, 0, 8'($urandom), 8'($urandom), rnd(3),
              8'($urandom), rnd(2), rnd(8), 0, 0);
        default:
          cyc(0, 0, 0, 8'h00, 8'h00, rnd(3), 8'($urandom),
              rnd(2), rnd(8), 0, 0);
      endcase
    end

    idle(2, 0);
    @(negedge clk);
    chk("sb_rd_left", 8'(sb_rd.size()), 8'h00);
    chk("sb_tx_left", 8'(sb_tx.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
